tdc_fifo_reader: RTL and testbench
==================================

TDC_FIFO_READER -- requirements
Module: tdc_fifo_reader

Interface
REQ-001 The block SHALL have parameter SYNC_BYTE, default 8'hA5, the frame header byte.
REQ-002 The block SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port enable  input  1  high permits new frames to start.
REQ-005 The block SHALL have port fifo_empty  input  1  measurement FIFO holds no records.
REQ-006 The block SHALL have port fifo_dout  input  48  record {calib2[47:32], calib1[31:16], time1[15:0]}, valid the cycle after rd_en.
REQ-007 The block SHALL have port rd_en  output  1  single-cycle FIFO read strobe, registered.
REQ-008 The block SHALL have port tx_data  output  8  byte to the UART transmitter, registered.
REQ-009 The block SHALL have port new_tx_data  output  1  single-cycle strobe; tx_data is valid while it is high.
REQ-010 The block SHALL have port tx_busy  input  1  the UART transmitter is shifting a byte.
REQ-011 The block SHALL have port busy  output  1  high from the READ state through the last byte's HOLD state.
REQ-012 The block SHALL have port frame_count  output  16  count of completed frames.

Function
REQ-013 The block SHALL implement states IDLE, READ, LATCH, SEND and HOLD.
REQ-014 In IDLE, when enable=1 and fifo_empty=0, the block SHALL assert rd_en for exactly one cycle while in READ, then enter LATCH.
REQ-015 In IDLE, when enable=0 or fifo_empty=1, the block SHALL remain in IDLE with rd_en=0.
REQ-016 In LATCH, the block SHALL capture fifo_dout into a 48-bit holding register, set byte index to 0 and enter SEND; LATCH lasts one cycle.
REQ-017 The frame SHALL be 8 bytes in this order: SYNC_BYTE, time1[15:8], time1[7:0], calib1[15:8], calib1[7:0], calib2[15:8], calib2[7:0], checksum.
REQ-018 The checksum SHALL be the bitwise XOR of frame bytes 1-6; SYNC_BYTE is excluded.
REQ-019 In SEND, while tx_busy=1 the block SHALL wait with new_tx_data=0.
REQ-020 In SEND, when tx_busy=0 the block SHALL drive tx_data with the indexed byte, pulse new_tx_data for one cycle and enter HOLD.
REQ-021 HOLD SHALL last exactly one cycle and ignore tx_busy, to absorb the UART's one-cycle busy latency.
REQ-022 From HOLD at byte index < 7, the block SHALL increment the index and return to SEND.
REQ-023 From HOLD at byte index 7, the block SHALL increment frame_count and return to IDLE.
REQ-024 frame_count SHALL wrap from 16'hFFFF to 16'h0000 with no flag.
REQ-025 tx_data SHALL hold its last value between strobes.
REQ-026 Minimum spacing between new_tx_data pulses SHALL be 2 cycles.
REQ-027 Minimum latency from IDLE with fifo_empty=0 to the first new_tx_data SHALL be 3 cycles: READ, LATCH, SEND.
REQ-028 If enable drops mid-frame, the current frame SHALL complete; no new frame SHALL start until enable=1.
REQ-029 fifo_empty SHALL be sampled only in IDLE; changes during a frame SHALL have no effect.
REQ-030 rd_en SHALL never be asserted outside READ; at most one read SHALL occur per frame.
REQ-031 Back-to-back records SHALL each yield a full frame, with at least one IDLE cycle between frames.

Reset
REQ-032 While rst=1, the block SHALL set state=IDLE, rd_en=0, new_tx_data=0, tx_data=8'h00, busy=0, frame_count=0, byte index=0 and holding register=0.
REQ-033 rst asserted mid-frame SHALL abort the frame immediately, issue no further strobes, and not consume any additional FIFO record.
REQ-034 The first strobe after rst deasserts SHALL be SYNC_BYTE of a new frame.

Verification
REQ-035 Bench SHALL cover single record: fifo_dout=48'h0003_0002_1234, tx_busy idle -> bytes A5,12,34,00,02,00,03,27; frame_count=1; one rd_en pulse.
REQ-036 Bench SHALL cover UART backpressure: tx_busy held high for 100 cycles after each strobe -> same 8 bytes, one strobe per byte, none lost or duplicated.
REQ-037 Bench SHALL cover enable dropped at byte 3 with 2 records queued -> frame 1 completes; rd_en=0 until enable=1; then frame 2 is sent.
REQ-038 Bench SHALL cover rst asserted at byte 4 -> outputs go to reset values next cycle; a following record produces a complete frame starting with A5; frame_count=1.
REQ-039 Bench SHALL cover wrap: preload frame_count to 16'hFFFF, send one frame -> frame_count=16'h0000.
REQ-040 Bench SHALL cover fifo_empty=1 with enable=1 for 1000 cycles -> rd_en, new_tx_data and busy stay 0.

Source files
------------

// File: rtl/tdc_fifo_reader.sv
// Pulls one 48-bit TDC record per frame from the measurement FIFO and sends it
// to a UART as an 8-byte frame: sync byte, six data bytes, XOR checksum.
module tdc_fifo_reader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [47:0] fifo_dout,
  output logic        rd_en,
  output logic [7:0]  tx_data,
  output logic        new_tx_data,
  input  logic        tx_busy,
  output logic        busy,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {IDLE, READ, LATCH, SEND, HOLD} state_t;

  state_t      state_q, state_d;
  logic [47:0] hold_q, hold_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        new_tx_q, new_tx_d;
  logic        rd_en_q, rd_en_d;
  logic        busy_q, busy_d;
  logic [7:0]  checksum;
  logic [7:0]  frame_bytes [8];

  // Each 16-bit field goes out high byte first: time1, calib1, calib2.
  assign frame_bytes[0] = SYNC_BYTE;
  for (genvar gi = 0; gi < 3; gi++) begin : g_field
    assign frame_bytes[2*gi+1] = hold_q[16*gi+8 +: 8];
    assign frame_bytes[2*gi+2] = hold_q[16*gi   +: 8];
  end
  assign frame_bytes[7] = checksum;

  always_comb begin
    checksum = 8'h00;
    for (int i = 0; i < 6; i++) begin
      checksum = checksum ^ hold_q[8*i +: 8];
    end
  end

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    idx_d         = idx_q;
    frame_count_d = frame_count_q;
    tx_data_d     = tx_data_q;
    new_tx_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && !fifo_empty) begin
          state_d = READ;
        end
      end
      READ: begin
        state_d = LATCH;
      end
      LATCH: begin
        hold_d  = fifo_dout;
        idx_d   = 3'd0;
        state_d = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          tx_data_d = frame_bytes[idx_q];
          new_tx_d  = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        // tx_busy is not looked at here: the UART raises it one cycle late.
        if (idx_q == 3'd7) begin
          frame_count_d = frame_count_q + 16'd1;
          state_d       = IDLE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    rd_en_d = (state_d == READ);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      idx_q         <= '0;
      frame_count_q <= '0;
      tx_data_q     <= '0;
      new_tx_q      <= 1'b0;
      rd_en_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      idx_q         <= idx_d;
      frame_count_q <= frame_count_d;
      tx_data_q     <= tx_data_d;
      new_tx_q      <= new_tx_d;
      rd_en_q       <= rd_en_d;
      busy_q        <= busy_d;
    end
  end

  assign rd_en       = rd_en_q;
  assign tx_data     = tx_data_q;
  assign new_tx_data = new_tx_q;
  assign busy        = busy_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_tdc_fifo_reader.sv
// Randomized bench for tdc_fifo_reader: FIFO and UART models plus a frame
// scoreboard built from the record layout and checksum rule.
module tb_tdc_fifo_reader;

  localparam logic [7:0]  SYNC = 8'hA5;
  localparam logic [63:0] REF_FRAME = 64'hA512_3400_0200_0327;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [47:0] fifo_dout = '0;
  logic        tx_busy = 1'b0;
  logic        rd_en;
  logic [7:0]  tx_data;
  logic        new_tx_data;
  logic        busy;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  tdc_fifo_reader #(.SYNC_BYTE(SYNC)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .fifo_empty  (fifo_empty),
    .fifo_dout   (fifo_dout),
    .rd_en       (rd_en),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data),
    .tx_busy     (tx_busy),
    .busy        (busy),
    .frame_count (frame_count)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  logic [47:0] fifo_q [$];
  logic [7:0]  exp_q [$];
  logic [7:0]  rx_log [$];
  int          n_reads = 0;
  int          frames_seen = 0;
  int          byte_in_frame = 0;
  int          busy_len = 0;
  int          busy_cnt = 0;
  int          cyc = 0;
  int          t_nonempty = 0;
  int          t_rd = 0;
  int          t_first = 0;
  int          last_strobe = -100;
  int          min_gap = 1000;
  logic        busy_prev = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: sync, time1 hi/lo, calib1 hi/lo, calib2 hi/lo, XOR of the six.
  function automatic logic [63:0] build_frame(input logic [47:0] rec);
    logic [7:0] b [8];
    b[0] = SYNC;
    b[1] = rec[15:8];
    b[2] = rec[7:0];
    b[3] = rec[31:24];
    b[4] = rec[23:16];
    b[5] = rec[47:40];
    b[6] = rec[39:32];
    b[7] = 8'h00;
    for (int i = 1; i <= 6; i++) b[7] = b[7] ^ b[i];
    return {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
  endfunction

  function automatic logic [63:0] rx_word(input int base);
    logic [63:0] w = '0;
    for (int i = 0; i < 8; i++) begin
      if (base + i < rx_log.size()) w = {w[55:0], rx_log[base+i]};
    end
    return w;
  endfunction

  // Monitor, FIFO model and UART model, all on the falling edge.
  always @(negedge clk) begin : mon
    logic [63:0] f;
    cyc++;
    if (rst) begin
      byte_in_frame = 0;
    end else begin
      if (new_tx_data) begin
        rx_log.push_back(tx_data);
        if (cyc - last_strobe < min_gap) min_gap = cyc - last_strobe;
        last_strobe = cyc;
        if (byte_in_frame == 0) t_first = cyc;
        byte_in_frame++;
        if (exp_q.size() == 0) check("byte_expected", 64'(exp_q.size()), 64'd1);
        else check("tx_byte", 64'(tx_data), 64'(exp_q.pop_front()));
      end
      if (rd_en) begin
        n_reads++;
        t_rd = cyc;
        check("rd_nonempty", 64'(fifo_q.size() != 0), 64'd1);
        if (fifo_q.size() != 0) begin
          fifo_dout = fifo_q.pop_front();
          f = build_frame(fifo_dout);
          for (int i = 7; i >= 0; i--) exp_q.push_back(f[8*i +: 8]);
        end
      end
      if (busy_prev && !busy) begin
        frames_seen++;
        check("frame_len", 64'(byte_in_frame), 64'd8);
        byte_in_frame = 0;
      end
    end
    busy_prev = busy;
    if (fifo_empty && fifo_q.size() != 0) t_nonempty = cyc;
    fifo_empty = (fifo_q.size() == 0);
    if (new_tx_data && !rst) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    tx_busy = (busy_cnt > 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int tgt;
    int k;
    tgt = frames_seen + n;
    k = 0;
    while (frames_seen < tgt && k < budget) begin
      tick();
      k++;
    end
    if (frames_seen < tgt) check("frame_timeout", 64'(frames_seen), 64'(tgt));
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int k;
    k = 0;
    while (byte_in_frame < n && k < budget) begin
      tick();
      k++;
    end
    if (byte_in_frame < n) check("byte_timeout", 64'(byte_in_frame), 64'(n));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int rd0;
    int cnt;
    logic [47:0] rec;

    rst = 1'b1;
    repeat (3) tick();
    check("rst_rd_en", 64'(rd_en), 64'd0);
    check("rst_new_tx", 64'(new_tx_data), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_count", 64'(frame_count), 64'd0);
    rst = 1'b0;
    enable = 1'b1;
    tick();

    // Single record, UART always ready.
    busy_len = 0;
    base = rx_log.size();
    rd0 = n_reads;
    fifo_q.push_back(48'h0003_0002_1234);
    wait_frames(1, 100);
    check("single_bytes", rx_word(base), REF_FRAME);
    check("single_count", 64'(frame_count), 64'd1);
    check("single_reads", 64'(n_reads - rd0), 64'd1);
    check("lat_idle_to_rd", 64'(t_rd - t_nonempty), 64'd1);
    check("lat_rd_to_strobe", 64'(t_first - t_rd), 64'd3);
    check("single_exp_empty", 64'(exp_q.size()), 64'd0);

    // UART backpressure: busy for 100 cycles after each strobe.
    busy_len = 100;
    base = rx_log.size();
    fifo_q.push_back(48'h0003_0002_1234);
    wait_frames(1, 2000);
    check("bp_bytes", rx_word(base), REF_FRAME);
    check("bp_nbytes", 64'(rx_log.size() - base), 64'd8);
    check("bp_count", 64'(frame_count), 64'd2);
    check("bp_exp_empty", 64'(exp_q.size()), 64'd0);

    // Back-to-back random records with random UART latency.
    busy_len = $urandom_range(0, 4);
    rd0 = n_reads;
    for (int r = 0; r < 4; r++) begin
      rec = {16'($urandom), 32'($urandom)};
      fifo_q.push_back(rec);
    end
    wait_frames(4, 600);
    check("b2b_count", 64'(frame_count), 64'd6);
    check("b2b_reads", 64'(n_reads - rd0), 64'd4);
    check("b2b_exp_empty", 64'(exp_q.size()), 64'd0);

    // Enable dropped at byte 3 with two records queued.
    busy_len = $urandom_range(0, 3);
    rd0 = n_reads;
    for (int r = 0; r < 2; r++) begin
      rec = {16'($urandom), 32'($urandom)};
      fifo_q.push_back(rec);
    end
    wait_bytes(3, 200);
    enable = 1'b0;
    wait_frames(1, 200);
    repeat (50) tick();
    check("en_low_reads", 64'(n_reads - rd0), 64'd1);
    check("en_low_fifo", 64'(fifo_q.size()), 64'd1);
    check("en_low_busy", 64'(busy), 64'd0);
    check("en_low_count", 64'(frame_count), 64'd7);
    enable = 1'b1;
    wait_frames(1, 200);
    check("en_high_count", 64'(frame_count), 64'd8);
    check("en_high_reads", 64'(n_reads - rd0), 64'd2);
    check("en_exp_empty", 64'(exp_q.size()), 64'd0);

    // Reset at byte 4 aborts the frame without consuming another record.
    busy_len = 0;
    rd0 = n_reads;
    fifo_q.push_back({16'($urandom), 32'($urandom)});
    wait_bytes(4, 100);
    rst = 1'b1;
    tick();
    check("abort_rd_en", 64'(rd_en), 64'd0);
    check("abort_new_tx", 64'(new_tx_data), 64'd0);
    check("abort_tx_data", 64'(tx_data), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_count", 64'(frame_count), 64'd0);
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("abort_reads", 64'(n_reads - rd0), 64'd1);
    base = rx_log.size();
    fifo_q.push_back({16'($urandom), 32'($urandom)});
    wait_frames(1, 100);
    check("post_rst_first", 64'(rx_word(base) >> 56), 64'(SYNC));
    check("post_rst_count", 64'(frame_count), 64'd1);
    check("post_rst_reads", 64'(n_reads - rd0), 64'd2);
    check("post_rst_exp_empty", 64'(exp_q.size()), 64'd0);

    // frame_count wraps from FFFF to 0000.
    force dut.frame_count_q = 16'hFFFF;
    tick();
    tick();
    release dut.frame_count_q;
    tick();
    check("wrap_preload", 64'(frame_count), 64'hFFFF);
    fifo_q.push_back({16'($urandom), 32'($urandom)});
    wait_frames(1, 100);
    check("wrap_count", 64'(frame_count), 64'd0);

    // Empty FIFO with enable high: everything stays quiet.
    rd0 = n_reads;
    cnt = 0;
    repeat (1000) begin
      tick();
      if (rd_en || new_tx_data || busy) cnt++;
    end
    check("empty_quiet", 64'(cnt), 64'd0);
    check("empty_reads", 64'(n_reads - rd0), 64'd0);

    check("strobe_spacing", 64'(min_gap >= 2), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
